// File: rtl/wb_cmd_master.sv
// wb_cmd_master: Wishbone classic single-cycle master fed by command/response FIFOs.
// Define WB_CMD_TIMEOUT_EN to abort unacknowledged cycles after TIMEOUT cycles with an error response.
module wb_cmd_master #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  parameter int CMD_DEPTH  = 4,
  parameter int RSP_DEPTH  = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic                       cmd_we_i,
  input  logic [ADDR_WIDTH-1:0]      cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]      cmd_data_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [DATA_WIDTH-1:0]      rsp_data_o,
  output logic                       rsp_err_o,
  output logic                       cyc_o,
  output logic                       stb_o,
  output logic                       we_o,
  output logic [ADDR_WIDTH-1:0]      adr_o,
  output logic [DATA_WIDTH-1:0]      dat_o,
  input  logic [DATA_WIDTH-1:0]      dat_i,
  input  logic                       ack_i,
  output logic                       busy_o,
  output logic [$clog2(CMD_DEPTH):0] cmd_count_o
);
  localparam int CW = $clog2(CMD_DEPTH);
  localparam int RW = $clog2(RSP_DEPTH);
  localparam int EW = 1 + ADDR_WIDTH + DATA_WIDTH;
`ifdef WB_CMD_TIMEOUT_EN
  localparam int RSPW = DATA_WIDTH + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
`else
  localparam int RSPW = DATA_WIDTH;
`endif
  if (CMD_DEPTH < 2 || RSP_DEPTH < 2 || TIMEOUT < 1) begin : g_bad_param
    $error("wb_cmd_master: invalid parameters");
  end
  typedef enum logic [1:0] {IDLE, BUS, GAP} state_t;
  state_t state_q, state_d;
  logic [EW-1:0] cmd_mem_q [CMD_DEPTH];
  logic [EW-1:0] cmd_mem_d [CMD_DEPTH];
  logic [RSPW-1:0] rsp_mem_q [RSP_DEPTH];
  logic [RSPW-1:0] rsp_mem_d [RSP_DEPTH];
  logic [CW:0] cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
  logic [RW:0] rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d, rsp_count;
  logic we_q, we_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [EW-1:0] cmd_head;
  logic [RSPW-1:0] rsp_head, rsp_in;
  logic cmd_push, cmd_empty, rsp_push, rsp_pop, rsp_full, go, done;
  assign cmd_count_o = cmd_wr_q - cmd_rd_q;
  assign cmd_empty   = cmd_count_o == '0;
  assign cmd_ready_o = cmd_count_o != (CW+1)'(CMD_DEPTH);
  assign cmd_push    = cmd_valid_i && cmd_ready_o;
  assign cmd_head    = cmd_mem_q[cmd_rd_q[CW-1:0]];
  assign rsp_count   = rsp_wr_q - rsp_rd_q;
  assign rsp_full    = rsp_count == (RW+1)'(RSP_DEPTH);
  assign rsp_valid_o = rsp_count != '0;
  assign rsp_pop     = rsp_valid_o && rsp_ready_i;
  assign rsp_head    = rsp_mem_q[rsp_rd_q[RW-1:0]];
  assign rsp_data_o  = rsp_head[DATA_WIDTH-1:0];
  assign cyc_o       = state_q == BUS;
  assign stb_o       = cyc_o;
  assign we_o        = we_q;
  assign adr_o       = adr_q;
  assign dat_o       = dat_q;
  assign busy_o      = state_q != IDLE || !cmd_empty;
`ifdef WB_CMD_TIMEOUT_EN
  logic [TW-1:0] tmr_q, tmr_d;
  logic tmo;
  // ack on the expiry edge takes precedence, so tmo is qualified with !ack_i
  assign tmo       = cyc_o && !ack_i && tmr_q == TW'(TIMEOUT - 1);
  assign tmr_d     = cyc_o && !ack_i ? tmr_q + TW'(1) : '0;
  assign done      = cyc_o && (ack_i || tmo);
  assign go        = !cmd_empty && !rsp_full;
  assign rsp_push  = done && (!we_q || tmo);
  assign rsp_in    = tmo ? {1'b1, {DATA_WIDTH{1'b0}}} : {1'b0, dat_i};
  assign rsp_err_o = rsp_valid_o && rsp_head[DATA_WIDTH];
`else
  assign done      = cyc_o && ack_i;
  assign go        = !cmd_empty && (cmd_head[EW-1] || !rsp_full);
  assign rsp_push  = done && !we_q;
  assign rsp_in    = dat_i;
  assign rsp_err_o = 1'b0;
`endif
  assign cmd_wr_d = cmd_push ? cmd_wr_q + (CW+1)'(1) : cmd_wr_q;
  assign cmd_rd_d = done ? cmd_rd_q + (CW+1)'(1) : cmd_rd_q;
  assign rsp_wr_d = rsp_push ? rsp_wr_q + (RW+1)'(1) : rsp_wr_q;
  assign rsp_rd_d = rsp_pop ? rsp_rd_q + (RW+1)'(1) : rsp_rd_q;
  always_comb begin
    cmd_mem_d = cmd_mem_q;
    rsp_mem_d = rsp_mem_q;
    if (cmd_push) cmd_mem_d[cmd_wr_q[CW-1:0]] = {cmd_we_i, cmd_addr_i, cmd_data_i};
    if (rsp_push) rsp_mem_d[rsp_wr_q[RW-1:0]] = rsp_in;
  end
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    case (state_q)
      IDLE: if (go) begin
        state_d = BUS;
        {we_d, adr_d, dat_d} = cmd_head;
      end
      BUS: if (done) begin
        state_d = GAP;
        we_d    = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    cmd_mem_q <= cmd_mem_d;
    rsp_mem_q <= rsp_mem_d;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      cmd_wr_q <= '0;
      cmd_rd_q <= '0;
      rsp_wr_q <= '0;
      rsp_rd_q <= '0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
`ifdef WB_CMD_TIMEOUT_EN
      tmr_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cmd_wr_q <= cmd_wr_d;
      cmd_rd_q <= cmd_rd_d;
      rsp_wr_q <= rsp_wr_d;
      rsp_rd_q <= rsp_rd_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
`ifdef WB_CMD_TIMEOUT_EN
      tmr_q    <= tmr_d;
`endif
    end
  end
endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: scoreboard bench for wb_cmd_master against a small Wishbone slave model.
module tb_wb_cmd_master;
  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  logic cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [1:0] cmd_addr_i, adr_o;
  logic [7:0] cmd_data_i, rsp_data_o, dat_o, dat_i;
  logic rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic cyc_o, stb_o, we_o, ack_i, busy_o;
  logic [2:0] cmd_count_o;
  typedef struct { logic we; logic [1:0] adr; logic [7:0] dat; int len; } bus_t;
  typedef struct { logic [7:0] d; logic e; } rsp_t;
  bus_t exp_bus[$];
  rsp_t exp_rsp[$];
  int checks = 0, passes = 0;
  int ack_wait = 0, wcnt = 0, ncyc = 0;
  bit ack_en = 1'b1;
  logic [7:0] regs [4] = '{8'h11, 8'hC3, 8'h22, 8'h33};

  wb_cmd_master #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .CMD_DEPTH(4), .RSP_DEPTH(4), .TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i),
    .busy_o(busy_o), .cmd_count_o(cmd_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic expect_rsp(input logic [7:0] d, input logic e);
    rsp_t r;
    r.d = d;
    r.e = e;
    exp_rsp.push_back(r);
  endtask

  task automatic send(input logic we, input logic [1:0] a, input logic [7:0] d, input int len);
    int n = 0;
    bus_t b;
    b.we = we; b.adr = a; b.dat = d; b.len = len;
    exp_bus.push_back(b);
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = a; cmd_data_i = d;
    @(negedge clk_i);
    while (!cmd_ready_o && n < 100) begin @(negedge clk_i); n++; end
    check("cmd_accept", cmd_ready_o, 1);
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk_i);
    while ((busy_o || cyc_o) && n < 200) begin @(negedge clk_i); n++; end
    check("idle_reached", busy_o, 0);
    @(posedge clk_i); #1;
  endtask

  task automatic wait_rsp();
    int n = 0;
    @(negedge clk_i);
    while (!rsp_valid_o && n < 100) begin @(negedge clk_i); n++; end
    check("rsp_arrived", rsp_valid_o, 1);
  endtask

  initial forever begin
    @(negedge clk_i);
    if (cyc_o && stb_o && ack_en) begin
      ack_i = wcnt == ack_wait;
      dat_i = ack_i ? regs[adr_o] : 8'hEE;
      if (ack_i && we_o) regs[adr_o] = dat_o;
      wcnt = ack_i ? 0 : wcnt + 1;
    end else begin
      ack_i = 1'b0;
      dat_i = 8'hEE;
      if (!cyc_o) wcnt = 0;
    end
  end

  initial begin : bus_mon
    int blen, low;
    bit had, bad;
    logic cwe;
    logic [1:0] cadr;
    logic [7:0] cdat;
    bus_t b;
    blen = 0; low = 0; had = 0; bad = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_n_i) begin
        blen = 0; low = 0; had = 0;
      end else begin
        check("stb_eq_cyc", stb_o, cyc_o);
        if (cyc_o) begin
          if (blen == 0) begin
            if (had) check("gap_len", low >= 2, 1);
            cwe = we_o; cadr = adr_o; cdat = dat_o; bad = 0;
          end else if (we_o !== cwe || adr_o !== cadr || dat_o !== cdat) bad = 1;
          blen++;
        end else begin
          if (blen != 0) begin
            ncyc++; had = 1; low = 0;
            check("gap_we", we_o, 0);
            check("gap_adr", adr_o, cadr);
            check("gap_dat", dat_o, cdat);
            check("bus_stable", bad, 0);
            check("bus_expected", exp_bus.size() != 0, 1);
            if (exp_bus.size() != 0) begin
              b = exp_bus.pop_front();
              check("bus_we", cwe, b.we);
              check("bus_adr", cadr, b.adr);
              if (b.we) check("bus_dat", cdat, b.dat);
              if (b.len != 0) check("bus_len", blen, b.len);
            end
            blen = 0;
          end
          low++;
        end
      end
    end
  end

  initial begin : rsp_mon
    rsp_t r;
    forever begin
      @(negedge clk_i);
      if (rst_n_i && rsp_valid_o && rsp_ready_i) begin
        check("rsp_expected", exp_rsp.size() != 0, 1);
        if (exp_rsp.size() != 0) begin
          r = exp_rsp.pop_front();
          check("rsp_data", rsp_data_o, r.d);
          check("rsp_err", rsp_err_o, r.e);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int base;
    cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_addr_i = '0; cmd_data_i = '0; rsp_ready_i = 1'b0;
    ack_i = 1'b0; dat_i = 8'hEE;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_cyc", cyc_o, 0); check("rst_stb", stb_o, 0); check("rst_we", we_o, 0);
    check("rst_adr", adr_o, 0); check("rst_dat", dat_o, 0); check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_rsp_err", rsp_err_o, 0); check("rst_busy", busy_o, 0); check("rst_count", cmd_count_o, 0);
    check("rst_ready", cmd_ready_o, 1);
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    // single write, three wait states
    ack_wait = 3;
    send(1'b1, 2'd2, 8'h5A, 4);
    check("t1_count", cmd_count_o, 1);
    check("t1_cyc_latency", cyc_o, 0);
    @(posedge clk_i); #1;
    check("t1_cyc", cyc_o, 1); check("t1_we", we_o, 1); check("t1_adr", adr_o, 2);
    check("t1_dat", dat_o, 8'h5A); check("t1_busy", busy_o, 1);
    wait_idle();
    check("t1_no_rsp", rsp_valid_o, 0);
    check("t1_count_end", cmd_count_o, 0);
    // read with response held, then popped
    ack_wait = 1;
    expect_rsp(8'hC3, 1'b0);
    send(1'b0, 2'd1, 8'h00, 2);
    wait_rsp();
    check("t2_data", rsp_data_o, 8'hC3); check("t2_err", rsp_err_o, 0); check("t2_cyc_off", cyc_o, 0);
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    check("t2_popped", rsp_valid_o, 0);
    expect_rsp(8'h5A, 1'b0);
    send(1'b0, 2'd2, 8'h00, 2);
    wait_idle();
    // command FIFO fill with ack withheld
    ack_wait = 0;
    ack_en = 1'b0;
    send(1'b1, 2'd0, 8'hA0, 0);
    send(1'b1, 2'd1, 8'hA1, 1);
    send(1'b1, 2'd3, 8'hA3, 1);
    send(1'b1, 2'd2, 8'hA2, 1);
    check("t3_count_full", cmd_count_o, 4); check("t3_ready_low", cmd_ready_o, 0); check("t3_cyc", cyc_o, 1);
    cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_addr_i = 2'd0; cmd_data_i = 8'hB0;
    repeat (3) @(posedge clk_i);
    #1;
    check("t3_no_bypass", cmd_count_o, 4); check("t3_still_full", cmd_ready_o, 0);
    ack_en = 1'b1;
    send(1'b1, 2'd0, 8'hB0, 1);
    check("t3_count_refill", cmd_count_o, 4);
    wait_idle();
    // response FIFO full holds the fifth read in IDLE
    rsp_ready_i = 1'b0;
    base = ncyc;
    expect_rsp(8'hB0, 1'b0); expect_rsp(8'hA1, 1'b0); expect_rsp(8'hA2, 1'b0);
    expect_rsp(8'hA3, 1'b0); expect_rsp(8'hB0, 1'b0);
    send(1'b0, 2'd0, 8'h00, 1);
    send(1'b0, 2'd1, 8'h00, 1);
    send(1'b0, 2'd2, 8'h00, 1);
    send(1'b0, 2'd3, 8'h00, 1);
    send(1'b0, 2'd0, 8'h00, 1);
    repeat (20) @(posedge clk_i);
    #1;
    check("t4_cycles_held", ncyc - base, 4); check("t4_cyc_off", cyc_o, 0);
    check("t4_count", cmd_count_o, 1); check("t4_rsp_valid", rsp_valid_o, 1); check("t4_busy", busy_o, 1);
    rsp_ready_i = 1'b1;
    wait_idle();
    repeat (3) @(posedge clk_i);
    #1;
    check("t4_cycles_all", ncyc - base, 5); check("t4_drained", rsp_valid_o, 0);
    // asynchronous reset mid-cycle
    ack_en = 1'b0;
    send(1'b1, 2'd1, 8'hEE, 0);
    send(1'b1, 2'd2, 8'hEF, 0);
    check("t5_count", cmd_count_o, 2); check("t5_cyc", cyc_o, 1);
    #2 rst_n_i = 1'b0;
    #1;
    check("t5_cyc_drop", cyc_o, 0); check("t5_stb_drop", stb_o, 0); check("t5_count_clr", cmd_count_o, 0);
    check("t5_busy", busy_o, 0); check("t5_ready", cmd_ready_o, 1); check("t5_no_rsp", rsp_valid_o, 0);
    exp_bus.delete();
    @(posedge clk_i);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    ack_en = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("t5_idle_cyc", cyc_o, 0); check("t5_idle_ready", cmd_ready_o, 1); check("t5_idle_busy", busy_o, 0);
    expect_rsp(8'hA1, 1'b0);
    send(1'b0, 2'd1, 8'h00, 1);
    wait_idle();
`ifdef WB_CMD_TIMEOUT_EN
    begin
      int n = 0;
      ack_en = 1'b0;
      expect_rsp(8'h00, 1'b1);
      send(1'b1, 2'd3, 8'h77, 8);
      expect_rsp(8'hA3, 1'b0);
      send(1'b0, 2'd3, 8'h00, 1);
      @(negedge clk_i);
      while (cyc_o && n < 100) begin @(negedge clk_i); n++; end
      check("t6_aborted", cyc_o, 0);
      @(posedge clk_i); #1;
      ack_en = 1'b1;
      wait_idle();
      repeat (3) @(posedge clk_i);
      #1;
    end
`endif
    repeat (3) @(posedge clk_i);
    #1;
    check("exp_rsp_left", exp_rsp.size(), 0);
    check("exp_bus_left", exp_bus.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
- Parametrised hardware Wishbone classic-cycle master: the synthesisable successor to the testbench-side Wishbone driver.
- Queues register-access commands from a local valid/ready port in a command FIFO.
- Executes each command as one Wishbone classic single cycle toward the IICMB register file.
- Returns read data through a response FIFO.
- Used as the on-chip host front-end for multi-bus IICMB configurations.

Parameters:
- ADDR_WIDTH, 2, Wishbone address width.
- DATA_WIDTH, 8, Wishbone data width.
- CMD_DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- RSP_DEPTH, 4, response FIFO entries; power of 2, minimum 2.
- TIMEOUT, 255, ack wait limit in cycles; used only with WB_CMD_TIMEOUT_EN; minimum 1.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  command offered.
- cmd_ready_o  out  1  command FIFO not full.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  ADDR_WIDTH  register address.
- cmd_data_i  in  DATA_WIDTH  write data; ignored for reads.
- rsp_valid_o  out  1  response FIFO not empty.
- rsp_ready_i  in  1  response consumed.
- rsp_data_o  out  DATA_WIDTH  head response data.
- rsp_err_o  out  1  head response is a timeout error.
- cyc_o, stb_o, we_o  out  1 each  Wishbone master controls.
- adr_o  out  ADDR_WIDTH  Wishbone address.
- dat_o  out  DATA_WIDTH  Wishbone write data.
- dat_i  in  DATA_WIDTH  Wishbone read data.
- ack_i  in  1  Wishbone acknowledge.
- busy_o  out  1  FSM not IDLE or command FIFO not empty.
- cmd_count_o  out  $clog2(CMD_DEPTH)+1  command FIFO occupancy.

Behaviour:
- Reset (asynchronous, rst_n_i low):
  - cyc_o, stb_o, we_o, adr_o, dat_o, rsp_valid_o, rsp_err_o, busy_o and cmd_count_o are 0.
  - cmd_ready_o is 1.
  - Both FIFOs are emptied; FSM goes to IDLE.
  - Reset mid-cycle drops cyc_o/stb_o immediately; the in-flight command is discarded and no response is produced.
- Command push: occurs on an edge where cmd_valid_i and cmd_ready_o are both high. cmd_ready_o equals !full, taken before any same-cycle pop; there is no bypass into a full FIFO.
- Response pop: occurs on an edge where rsp_valid_o and rsp_ready_i are both high. rsp_data_o and rsp_err_o are combinational from the FIFO head.
- FSM states:
  - IDLE:
    - Go to BUS when the command FIFO is non-empty AND (head is a write OR the response FIFO is not full).
    - A read whose response could not be stored is held in IDLE.
  - BUS:
    - cyc_o = stb_o = 1.
    - we_o, adr_o and dat_o are registered from the FIFO head on entry and held stable until exit.
    - On the edge where ack_i = 1, pop the command.
    - For a read, push dat_i sampled at that edge with err = 0.
    - Go to GAP.
  - GAP:
    - cyc_o = stb_o = 0 for exactly one cycle, then IDLE.
    - Write data and address outputs are held; we_o is cleared.
- Latency:
  - Command accepted at edge k: FIFO non-empty after k, and cyc_o rises after edge k+1.
  - ack_i sampled at edge m: cyc_o falls and the read response is visible after edge m.
  - The next cyc_o rises after edge m+2 at the earliest.
- Writes produce no response, except timeout errors (see Optional Feature).
- ack_i is ignored outside BUS.
- Commands execute strictly in order; there is no reordering between reads and writes.

Optional Feature:
- Macro: WB_CMD_TIMEOUT_EN.
- Defined:
  - A counter clears on BUS entry and increments each cycle in BUS without ack_i.
  - When it reaches TIMEOUT with no ack_i, the cycle is aborted: cyc_o/stb_o drop, the command is popped, and the FSM goes to GAP.
  - The abort pushes a response with data 0 and err = 1 for both reads and writes.
  - Because a write may then need a response slot, IDLE also requires the response FIFO not full before issuing a write.
  - If ack_i arrives on the same edge as the timeout, ack_i wins: normal completion, err = 0.
- Undefined:
  - BUS waits indefinitely for ack_i.
  - rsp_err_o is tied 0 and no counter logic exists.

Test Plan:
- Single write (addr 2, data 0x5A, ack after 3 wait cycles) -> cyc_o/stb_o high 4 cycles with adr_o = 2, dat_o = 0x5A, we_o = 1 stable; no response; busy_o clears after GAP.
- Read (addr 1, slave returns 0xC3 with ack) -> rsp_valid_o = 1, rsp_data_o = 0xC3, rsp_err_o = 0 the cycle after ack; cleared after the rsp_ready_i pop.
- Push 5 commands with ack_i held 0, CMD_DEPTH = 4 -> first 4 accepted (the first enters BUS and stays in the FIFO), cmd_count_o = 4, cmd_ready_o = 0; after one ack a slot frees and the 5th is accepted.
- Issue 5 reads with rsp_ready_i = 0, RSP_DEPTH = 4 -> exactly 4 Wishbone cycles; the 5th is held in IDLE with cyc_o = 0 until one response is popped, then issues.
- rst_n_i asserted low during BUS with 2 commands queued -> cyc_o/stb_o drop asynchronously, cmd_count_o = 0, no response; after release, idle with cmd_ready_o = 1.
- With WB_CMD_TIMEOUT_EN and TIMEOUT = 8, write with no ack -> stb_o high exactly 8 cycles; response data 0x00, err = 1; the next queued command then proceeds normally.
